// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions: machine width, reset vector, address type.
`timescale 1ns / 1ps
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   typedef logic [XLEN-1:0] addr_t;

   localparam addr_t PC_RESET_VECTOR = 32'h0000_0000;

endpackage : riscv_pkg

// File: rtl/dff_ar.sv
// Generic WIDTH-bit rising-edge register with asynchronous active-high reset.
`timescale 1ns / 1ps
module dff_ar #(
   parameter int unsigned        WIDTH       = 32,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= RESET_VALUE;
      end else begin
         q <= d;
      end
   end

endmodule : dff_ar

// File: rtl/pc_reg.sv
// Program-counter register: captures the next PC every rising clk edge.
// Define PC_ALIGN_MASK_EN to force PC_out[1:0] (and the reset value) to 2'b00.
`timescale 1ns / 1ps
module pc_reg
   import riscv_pkg::*;
#(
   parameter int unsigned      WIDTH       = XLEN,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VECTOR)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] PC_in,
   output logic [WIDTH-1:0] PC_out
);

   logic [WIDTH-1:0] pc_next;

`ifdef PC_ALIGN_MASK_EN
   // Word alignment: low two address bits are hard-wired to zero.
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
   localparam logic [WIDTH-1:0] RST_VAL    = RESET_VALUE & ALIGN_MASK;

   assign pc_next = PC_in & ALIGN_MASK;
`else
   localparam logic [WIDTH-1:0] RST_VAL    = RESET_VALUE;

   assign pc_next = PC_in;
`endif

   dff_ar #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RST_VAL)
   ) u_pc_ff (
      .clk (clk),
      .rst (rst),
      .d   (pc_next),
      .q   (PC_out)
   );

endmodule : pc_reg

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: vector table, directed corner cases, random run.
`timescale 1ns / 1ps
module tb_pc_reg;
   import riscv_pkg::*;

   localparam logic [31:0] RST_VAL = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic [31:0] PC_in;
   logic [31:0] PC_out;

   int checks   = 0;
   int failures = 0;

   pc_reg dut (
      .clk    (clk),
      .rst    (rst),
      .PC_in  (PC_in),
      .PC_out (PC_out)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #90000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   // What the register should present once value v has been captured.
   function automatic logic [31:0] stored(input logic [31:0] v);
`ifdef PC_ALIGN_MASK_EN
      return {v[31:2], 2'b00};
`else
      return v;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] exp);
      checks++;
      if (PC_out !== exp) begin
         failures++;
         $display("FAIL %s: PC_out=%h expected=%h at %0t", name, PC_out, exp, $time);
      end
   endtask

   typedef struct {
      logic        rst;
      logic [31:0] pc_in;
      logic [31:0] exp;
   } vec_t;

   vec_t   vecs[8];
   addr_t  seq_val;
   logic [31:0] model_pc;
   logic [31:0] v;

   initial begin
      vecs[0] = '{1'b0, 32'h0000_0004, 32'h0000_0004};
      vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[2] = '{1'b0, 32'h8000_0001, 32'h8000_0001};
      vecs[3] = '{1'b1, 32'h1234_5678, RST_VAL};
      vecs[4] = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
      vecs[6] = '{1'b0, 32'h0000_0002, 32'h0000_0002};
      vecs[7] = '{1'b0, 32'h0000_0278, 32'h0000_0278};

      // Power-up reset
      rst   = 1'b1;
      PC_in = 32'h0;
      #1 check("powerup_reset", stored(RST_VAL));
      #4 rst = 1'b0;
      @(posedge clk); #1 check("powerup_hold0", 32'h0);

      // Vector table: drive at falling edge, check after the next rising edge
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rst   = vecs[i].rst;
         PC_in = vecs[i].pc_in;
         if (vecs[i].rst) begin
            #1 check("vec_async_rst", stored(vecs[i].exp));
         end
         @(posedge clk); #1 check($sformatf("vec%0d", i), stored(vecs[i].exp));
      end

      // Capture 632 and hold through the falling edge
      @(negedge clk);
      PC_in = 32'd632;
      @(posedge clk); #1 check("capture_632", stored(32'd632));
      @(negedge clk); #1 check("hold_falling", stored(32'd632));

      // Falling-edge / low-phase immunity
      PC_in = 32'd14;
      #2 check("low_phase_immune", stored(32'd632));
      @(posedge clk); #1 check("load_14", stored(32'd14));

      // Zero-width reset pulse mid-operation
      @(negedge clk);
      PC_in = 32'd632;
      @(posedge clk); #1 check("reload_632", stored(32'd632));
      @(negedge clk); #2;
      rst = 1'b1;
      #0 rst = 1'b0;
      PC_in = 32'd37;
      #1 check("zero_width_rst", stored(RST_VAL));
      @(posedge clk); #1 check("after_pulse_37", stored(32'd37));

      // Sequential fetch: PC_in steps by 4 every 50 ns, off the clock edges
      @(negedge clk);
      fork
         begin
            seq_val = 32'd37;
            for (int k = 0; k < 6; k++) begin
               #3 PC_in = seq_val + 32'd4;
               seq_val = seq_val + 32'd4;
               #47;
            end
         end
      join_none
      for (int c = 0; c < 14; c++) begin
         @(posedge clk);
         model_pc = stored(PC_in);
         #1 check("seq_rise", model_pc);
         #9 check("seq_fall", model_pc);
      end
      wait fork;

      // Reset rising at the same instant as the clock edge: reset wins
      @(negedge clk);
      PC_in = 32'h0000_1000;
      @(posedge clk);
      rst = 1'b1;
      #1 check("rst_at_clk_edge", stored(RST_VAL));
      @(negedge clk); #2 rst = 1'b0;
      #1 check("rst_released_hold", stored(RST_VAL));
      @(posedge clk); #1 check("first_edge_after_rst", stored(32'h0000_1000));

      // Random run against a reference model (value last sampled at a rising edge)
      model_pc = stored(32'h0000_1000);
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         #($urandom_range(1, 8));
         v     = $urandom;
         PC_in = v;
         if ($urandom_range(0, 7) == 0) begin
            rst = 1'b1;
            #0 rst = 1'b0;
            model_pc = stored(RST_VAL);
            #1 check("rand_rst", model_pc);
         end else begin
            #1 check("rand_low_hold", model_pc);
         end
         @(posedge clk);
         model_pc = stored(v);
         #1 check("rand_capture", model_pc);
         #($urandom_range(1, 7));
         PC_in = $urandom;
         #1 check("rand_high_hold", model_pc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_pc_reg
